// File: rtl/audio_tone_mixer.sv
// Multi-tone square-wave generator mixed into a stereo sample stream with signed
// saturation, one valid/ready register stage, a scaled scope tap and a clip counter.
module audio_tone_mixer #(
    parameter int DATA_W    = 32,
    parameter int NUM_TONES = 2,
    parameter int DIV_W     = 19,
    parameter int AMP_W     = 16,
    parameter int SCOPE_LSB = 0
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic [NUM_TONES-1:0]       tone_en,
    input  logic [NUM_TONES*DIV_W-1:0] tone_half_period,
    input  logic [AMP_W-1:0]           tone_amp,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          left_in,
    input  logic [DATA_W-1:0]          right_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          left_out,
    output logic [DATA_W-1:0]          right_out,
    input  logic [3:0]                 scale,
    output logic [15:0]                scope_data,
    output logic [15:0]                clip_count
);

    // Returns {clipped, value}: sum formed one bit wider, clamped to the signed range.
    function automatic logic [DATA_W:0] sat_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        logic [DATA_W:0] res;
        s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        if (s[DATA_W] != s[DATA_W-1]) begin
            if (s[DATA_W]) begin
                res = {1'b1, 1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                res = {1'b1, 1'b0, {(DATA_W-1){1'b1}}};
            end
        end else begin
            res = {1'b0, s[DATA_W-1:0]};
        end
        return res;
    endfunction

    function automatic logic [15:0] scope_shift(input logic [15:0] v, input logic [3:0] sh);
        logic signed [15:0] sv;
        sv = v;
        return 16'(sv >>> sh);
    endfunction

    logic [DIV_W-1:0]     r_cnt [NUM_TONES];
    logic [NUM_TONES-1:0] r_phase;
    logic [DATA_W-1:0]    w_amp_ext;
    logic [DATA_W-1:0]    w_tone_sum;
    logic [DATA_W:0]      w_left_sat;
    logic [DATA_W:0]      w_right_sat;
    logic                 w_accept;
    logic                 w_clip_any;

    assign w_amp_ext   = {{(DATA_W-AMP_W){1'b0}}, tone_amp};
    assign in_ready    = !out_valid || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_left_sat  = sat_add(left_in, w_tone_sum);
    assign w_right_sat = sat_add(right_in, w_tone_sum);
    assign w_clip_any  = w_left_sat[DATA_W] || w_right_sat[DATA_W];

    // Half-period counters; the >= compare lets a shrunk half-period wrap immediately.
    always_ff @(posedge CLOCK_50) begin
        for (int i = 0; i < NUM_TONES; i++) begin
            if (reset || !tone_en[i]) begin
                r_cnt[i]   <= '0;
                r_phase[i] <= 1'b0;
            end else if (r_cnt[i] >= tone_half_period[i*DIV_W +: DIV_W]) begin
                r_cnt[i]   <= '0;
                r_phase[i] <= ~r_phase[i];
            end else begin
                r_cnt[i]   <= r_cnt[i] + DIV_W'(1);
            end
        end
    end

    // Signed sum of the +/-amp contributions of all enabled tones.
    always_comb begin
        w_tone_sum = '0;
        for (int i = 0; i < NUM_TONES; i++) begin
            if (tone_en[i]) begin
                if (r_phase[i]) begin
                    w_tone_sum = w_tone_sum + w_amp_ext;
                end else begin
                    w_tone_sum = w_tone_sum - w_amp_ext;
                end
            end else begin
                w_tone_sum = w_tone_sum;
            end
        end
    end

    // Output register stage: capture on accept, drop valid once consumed.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            out_valid  <= 1'b0;
            left_out   <= '0;
            right_out  <= '0;
            scope_data <= 16'h0000;
            clip_count <= 16'h0000;
        end else if (w_accept) begin
            out_valid  <= 1'b1;
            left_out   <= w_left_sat[DATA_W-1:0];
            right_out  <= w_right_sat[DATA_W-1:0];
            scope_data <= scope_shift(w_left_sat[SCOPE_LSB +: 16], scale);
            if (w_clip_any && (clip_count != 16'hFFFF)) begin
                clip_count <= clip_count + 16'd1;
            end else begin
                clip_count <= clip_count;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_audio_tone_mixer.sv
// Directed, table-driven bench for audio_tone_mixer with hand-computed expectations.
module tb_audio_tone_mixer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  tone_en;
    logic [37:0] tone_half_period;
    logic [15:0] tone_amp;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] left_in;
    logic [31:0] right_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] left_out;
    logic [31:0] right_out;
    logic [3:0]  scale;
    logic [15:0] scope_data;
    logic [15:0] clip_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    audio_tone_mixer dut (
        .CLOCK_50(clk), .reset(reset), .tone_en(tone_en),
        .tone_half_period(tone_half_period), .tone_amp(tone_amp),
        .in_valid(in_valid), .in_ready(in_ready),
        .left_in(left_in), .right_in(right_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .left_out(left_out), .right_out(right_out),
        .scale(scale), .scope_data(scope_data), .clip_count(clip_count)
    );

    typedef struct {
        logic [31:0] l_in;
        logic [31:0] r_in;
        logic [3:0]  sc;
        logic [31:0] exp_l;
        logic [31:0] exp_r;
        logic [15:0] exp_scope;
    } vec_t;

    vec_t vecs[6];

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    initial begin
        logic [31:0] e;

        vecs[0] = '{32'h00008000, 32'h12345678, 4'd0,  32'h00008000, 32'h12345678, 16'h8000};
        vecs[1] = '{32'h00008000, 32'hFFFFFFFF, 4'd3,  32'h00008000, 32'hFFFFFFFF, 16'hF000};
        vecs[2] = '{32'h00008000, 32'h00000000, 4'd15, 32'h00008000, 32'h00000000, 16'hFFFF};
        vecs[3] = '{32'h00004000, 32'h00000000, 4'd2,  32'h00004000, 32'h00000000, 16'h1000};
        vecs[4] = '{32'hFFFFFFFB, 32'h00000007, 4'd1,  32'hFFFFFFFB, 32'h00000007, 16'hFFFD};
        vecs[5] = '{32'h7FFFFFFF, 32'h80000000, 4'd4,  32'h7FFFFFFF, 32'h80000000, 16'hFFFF};

        // Reset held with activity present
        reset = 1'b1; tone_en = 2'b11; tone_half_period = {19'd1, 19'd1};
        tone_amp = 16'd1000; in_valid = 1'b1; out_ready = 1'b1;
        left_in = 32'h00001234; right_in = 32'h00005678; scale = 4'd0;
        repeat (3) step;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_left_out", left_out, 32'd0);
        chk("reset_scope", {16'b0, scope_data}, 32'd0);
        chk("reset_clip", {16'b0, clip_count}, 32'd0);
        reset = 1'b0; tone_en = 2'b00; in_valid = 1'b0;
        #1;
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        step;

        // Table: tones off, pass-through and scope shifts
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            left_in = vecs[i].l_in; right_in = vecs[i].r_in; scale = vecs[i].sc;
            step;
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("vec%0d_left", i), left_out, vecs[i].exp_l);
            chk($sformatf("vec%0d_right", i), right_out, vecs[i].exp_r);
            chk($sformatf("vec%0d_scope", i), {16'b0, scope_data}, {16'b0, vecs[i].exp_scope});
        end
        chk("table_clip", {16'b0, clip_count}, 32'd0);

        // Single tone, half period 4: five -1000 then five +1000
        tone_en = 2'b01; tone_half_period = {19'd0, 19'd4}; tone_amp = 16'd1000;
        left_in = 32'd0; right_in = 32'd0;
        for (int n = 1; n <= 20; n++) begin
            step;
            e = (((n - 1) / 5) % 2 == 0) ? 32'hFFFFFC18 : 32'h000003E8;
            chk($sformatf("tone1_left_%0d", n), left_out, e);
            chk($sformatf("tone1_right_%0d", n), right_out, e);
        end

        // Two tones in phase, then tone1 knocked one cycle out of step
        tone_en = 2'b00;
        step;
        tone_en = 2'b11; tone_half_period = {19'd9, 19'd9};
        for (int n = 1; n <= 10; n++) begin
            step;
            chk($sformatf("tone2_low_%0d", n), left_out, 32'hFFFFF830);
        end
        tone_en = 2'b01;
        step;
        chk("tone2_one_off", left_out, 32'h000003E8);
        tone_en = 2'b11;
        for (int n = 12; n <= 20; n++) begin
            step;
            chk($sformatf("tone2_cancel_%0d", n), left_out, 32'd0);
        end
        step;
        chk("tone2_realign", left_out, 32'hFFFFF830);

        // Saturation with phase=1 then phase=0
        tone_en = 2'b00; in_valid = 1'b0;
        step;
        tone_en = 2'b01; tone_half_period = {19'd0, 19'd0};
        step;
        tone_half_period = {19'd0, 19'd1000}; in_valid = 1'b1;
        left_in = 32'h7FFFFF00; right_in = 32'h80000100;
        step;
        chk("sat_pos_left", left_out, 32'h7FFFFFFF);
        chk("sat_pos_right", right_out, 32'h800004E8);
        chk("sat_pos_clip", {16'b0, clip_count}, 32'd1);
        tone_half_period = {19'd0, 19'd0}; in_valid = 1'b0;
        step;
        chk("sat_idle_valid", {31'b0, out_valid}, 32'd0);
        tone_half_period = {19'd0, 19'd1000}; in_valid = 1'b1;
        step;
        chk("sat_neg_left", left_out, 32'h7FFFFB18);
        chk("sat_neg_right", right_out, 32'h80000000);
        chk("sat_neg_clip", {16'b0, clip_count}, 32'd2);

        // Backpressure: A held, B stalled until out_ready rises
        tone_en = 2'b00; in_valid = 1'b0;
        step;
        out_ready = 1'b0; in_valid = 1'b1;
        left_in = 32'h11111111; right_in = 32'h11111111;
        #1;
        chk("bp_ready_before", {31'b0, in_ready}, 32'd1);
        step;
        chk("bp_a_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_a_left", left_out, 32'h11111111);
        chk("bp_not_ready", {31'b0, in_ready}, 32'd0);
        left_in = 32'h22222222; right_in = 32'h22222222;
        repeat (2) step;
        chk("bp_hold_left", left_out, 32'h11111111);
        chk("bp_hold_right", right_out, 32'h11111111);
        chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_comb", {31'b0, in_ready}, 32'd1);
        step;
        chk("bp_b_left", left_out, 32'h22222222);
        chk("bp_b_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step;
        chk("bp_drain", {31'b0, out_valid}, 32'd0);

        // Clip counter saturation at 0xFFFF
        tone_en = 2'b01; in_valid = 1'b1;
        left_in = 32'h7FFFFFFF; right_in = 32'h80000000;
        repeat (65532) step;
        chk("clip_fffe", {16'b0, clip_count}, 32'h0000FFFE);
        step;
        chk("clip_ffff", {16'b0, clip_count}, 32'h0000FFFF);
        repeat (5) step;
        chk("clip_hold", {16'b0, clip_count}, 32'h0000FFFF);

        // Reset drops the held sample
        reset = 1'b1;
        step;
        chk("rst2_valid", {31'b0, out_valid}, 32'd0);
        chk("rst2_clip", {16'b0, clip_count}, 32'd0);
        chk("rst2_right", right_out, 32'd0);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_tone_mixer.md
Name: audio_tone_mixer

Overview:
Parametrised successor to the single square-wave tone injector in the audio example top level. It generates NUM_TONES independently enabled square-wave tones, each with its own programmable half-period, and sums them. The sum is mixed into a stereo sample stream with signed saturation, through a single valid/ready register stage. The block also drives a scaled 16-bit scope tap for the VGA waveform display. It sits between the Audio_Controller input FIFO and output FIFO.

Parameters:
DATA_W, 32, audio sample width (signed, two's complement)
NUM_TONES, 2, number of independent tone generators
DIV_W, 19, half-period counter width
AMP_W, 16, tone amplitude magnitude width (unsigned); requires AMP_W+clog2(NUM_TONES)+1 <= DATA_W
SCOPE_LSB, 0, lowest bit of left_out copied to the scope tap (16 bits, SCOPE_LSB+15 <= DATA_W-1)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  synchronous, active-high reset
tone_en  in  NUM_TONES  per-tone enable
tone_half_period  in  NUM_TONES*DIV_W  tone i at [i*DIV_W +: DIV_W], in clock cycles minus one
tone_amp  in  AMP_W  common tone amplitude
in_valid  in  1  input sample pair available
in_ready  out  1  block accepts a sample this cycle
left_in  in  DATA_W  signed left sample
right_in  in  DATA_W  signed right sample
out_valid  out  1  output sample pair held
out_ready  in  1  downstream consumes the sample
left_out  out  DATA_W  mixed left sample
right_out  out  DATA_W  mixed right sample
scale  in  4  scope arithmetic right-shift amount
scope_data  out  16  scaled scope tap
clip_count  out  16  saturating count of clipped samples

Behaviour:
- Reset (CLOCK_50 edge with reset=1): all tone counters and phases 0; out_valid, left_out, right_out, scope_data and clip_count all 0. Any held sample is dropped. Reset overrides all other activity.
- Tone i, enabled:
  - if cnt_i >= half_period_i: cnt_i <= 0 and phase_i toggles; else cnt_i increments.
  - Period is therefore 2*(half_period_i+1) cycles; half_period 0 toggles every cycle.
  - A half_period lowered below the current cnt_i wraps on the next edge (>= compare, no overrun to 2^DIV_W).
- Tone i, disabled: cnt_i <= 0 and phase_i <= 0. On enable, the first toggle occurs after half_period_i+1 cycles.
- Tone contribution: +tone_amp if phase_i=1, -tone_amp if phase_i=0, 0 if disabled.
- tone_sum: signed sum of all contributions, computed combinationally from the current phases and sign-extended to DATA_W.
- Handshake: in_ready = !out_valid | out_ready (combinational). Accept = in_valid & in_ready.
  - On accept: left_out <= sat(left_in + tone_sum), right_out <= sat(right_in + tone_sum), out_valid <= 1. Latency is 1 cycle. tone_sum is sampled on the accept edge.
  - Else, if out_ready: out_valid <= 0.
  - Accept and consume in the same cycle gives back-to-back throughput of 1 sample/cycle.
  - left_out and right_out are stable while out_valid=1 and out_ready=0.
- Saturation:
  - Add in DATA_W+1 bits, then clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - clip_count increments by 1 per accepted sample in which either channel clamped, and holds at 0xFFFF.
- Scope:
  - On accept, scope_data <= the saturated left value bits [SCOPE_LSB+15:SCOPE_LSB], arithmetic-right-shifted by scale (sign fill from bit 15), using scale at that edge.
  - scale=15 yields all sign bits.
  - Otherwise scope_data holds.

Test Plan:
- Reset: hold reset 3 cycles with in_valid=1, tone_en=2'b11 -> out_valid=0, left_out=0, scope_data=0, clip_count=0; after release, in_ready=1.
- Single tone: tone_en=01, half_period0=4, amp=1000, left_in=right_in=0, in_valid every cycle, out_ready=1 -> outputs alternate between five -1000 samples and five +1000 samples, first transition 5 cycles after enable.
- Two tones: both half_period=9 enabled same cycle -> outputs ±2000. Then tone1 re-enabled 10 cycles later -> outputs 0.
- Saturation: left_in=0x7FFFFF00, right_in=0x80000100, single tone amp=1000 with phase=1 -> left_out=0x7FFFFFFF, right_out=0x800004E8, clip_count=1. With phase=0 -> right_out=0x80000000, clip_count=2.
- Backpressure: out_ready=0, samples A then B presented -> A accepted, in_ready=0, B not taken, left_out stays A. Raise out_ready -> B accepted on that edge.
- Scope: accepted left_out[15:0]=0x8000 with scale=0/3/15 -> scope_data=0x8000/0xF000/0xFFFF; left_out[15:0]=0x4000 with scale=2 -> 0x1000.
